canden_ctrl: RTL and testbench

- Sequencer that owns one CANDEN clock-gate cell and shares it between NREQ requesters.
- Turns the gate on when any requester asks for it, waits a fixed settle time, then acknowledges each requester.
- Keeps the gate on through short idle gaps and turns it off after a timeout.
- Drives the CANDEN select pins SEN, DEN and DYNEN glitch-free; the static/dynamic mode may change only while the gate is off.

---
 rtl/canden_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_canden_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/canden_ctrl.sv
// -----------------------------------------------------------------------------
// canden_ctrl
// Sequencer that owns one CANDEN clock-gate cell and shares it between NREQ
// requesters. Any request (or FORCE_ON) enables the gate. After WAKE_CYCLES
// settle cycles, each active requester is acknowledged. The gate is held
// through idle gaps of up to IDLE_CYCLES before it is switched off. The
// static/dynamic path select (DEN) only changes while the gate stays off.
//
// Ports:
//   CLK        system clock
//   RST        synchronous reset, active-high
//   REQ        [NREQ] per-requester clock request (level)
//   FORCE_ON   keeps the gate on; behaves as a request without an ACK
//   DYN_MODE   1 = dynamic enable path, 0 = static enable path
//   ACK        [NREQ] per-requester grant (registered)
//   SEN        static enable to CANDEN (registered)
//   DEN        dynamic-path select to CANDEN (registered)
//   DYNEN      dynamic enable to CANDEN (registered)
//   GATE_ON    high whenever STATE is not OFF
//   STATE      [2] OFF=0, WAKE=1, ON=2, HOLD=3
//
// Optional feature, macro CANDEN_CTRL_STATS_EN:
//   CLR_STATS  clears both statistics counters (wins over an increment)
//   WAKE_COUNT [16] number of gate turn-on events, saturating
//   ON_CYCLES  [16] number of cycles with GATE_ON high, saturating
// -----------------------------------------------------------------------------
module canden_ctrl #(
   parameter int NREQ        = 4,
   parameter int WAKE_CYCLES = 2,
   parameter int IDLE_CYCLES = 8
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic [NREQ-1:0] REQ,
   input  logic            FORCE_ON,
   input  logic            DYN_MODE,
`ifdef CANDEN_CTRL_STATS_EN
   input  logic            CLR_STATS,
   output logic [15:0]     WAKE_COUNT,
   output logic [15:0]     ON_CYCLES,
`endif
   output logic [NREQ-1:0] ACK,
   output logic            SEN,
   output logic            DEN,
   output logic            DYNEN,
   output logic            GATE_ON,
   output logic [1:0]      STATE
);

   // Parameter range checks; the counter is only 8 bits wide.
   if ((NREQ < 1) || (NREQ > 16)) begin : g_bad_nreq
      $error("canden_ctrl: NREQ must be in 1..16");
   end
   if ((WAKE_CYCLES < 0) || (WAKE_CYCLES > 255)) begin : g_bad_wake
      $error("canden_ctrl: WAKE_CYCLES must be in 0..255");
   end
   if ((IDLE_CYCLES < 0) || (IDLE_CYCLES > 255)) begin : g_bad_idle
      $error("canden_ctrl: IDLE_CYCLES must be in 0..255");
   end

   typedef enum logic [1:0] {
      ST_OFF  = 2'd0,
      ST_WAKE = 2'd1,
      ST_ON   = 2'd2,
      ST_HOLD = 2'd3
   } state_t;

   localparam logic [7:0] WAKE_LOAD = 8'(WAKE_CYCLES);
   localparam logic [7:0] IDLE_LOAD = 8'(IDLE_CYCLES);

   state_t            state_r;
   state_t            state_next_s;
   logic [7:0]        cnt_r;
   logic [7:0]        cnt_next_s;
   logic              any_s;
   logic              en_next_s;
   logic              den_next_s;
   logic [NREQ-1:0]   ack_next_s;
   logic [NREQ-1:0]   ack_r;
   logic              sen_r;
   logic              den_r;
   logic              dynen_r;
   logic              gate_on_r;

   assign any_s = (|REQ) | FORCE_ON;

   // Next-state and counter logic of the gate sequencer.
   always_comb begin
      state_next_s = state_r;
      cnt_next_s   = cnt_r;
      case (state_r)
         ST_OFF: begin
            if (any_s) begin
               if (WAKE_LOAD == 8'd0) begin
                  state_next_s = ST_ON;
                  cnt_next_s   = 8'd0;
               end else begin
                  state_next_s = ST_WAKE;
                  cnt_next_s   = WAKE_LOAD;
               end
            end else begin
               cnt_next_s = 8'd0;
            end
         end
         ST_WAKE: begin
            // Requests are not looked at here: a started wake always completes.
            if (cnt_r <= 8'd1) begin
               state_next_s = ST_ON;
               cnt_next_s   = 8'd0;
            end else begin
               cnt_next_s = cnt_r - 8'd1;
            end
         end
         ST_ON: begin
            if (!any_s) begin
               if (IDLE_LOAD == 8'd0) begin
                  state_next_s = ST_OFF;
                  cnt_next_s   = 8'd0;
               end else begin
                  state_next_s = ST_HOLD;
                  cnt_next_s   = IDLE_LOAD;
               end
            end else begin
               cnt_next_s = 8'd0;
            end
         end
         ST_HOLD: begin
            // A request on the expiry edge still wins and keeps the gate on.
            if (any_s) begin
               state_next_s = ST_ON;
               cnt_next_s   = 8'd0;
            end else if (cnt_r <= 8'd1) begin
               state_next_s = ST_OFF;
               cnt_next_s   = 8'd0;
            end else begin
               cnt_next_s = cnt_r - 8'd1;
            end
         end
         default: begin
            state_next_s = ST_OFF;
            cnt_next_s   = 8'd0;
         end
      endcase
   end

   // Next values of the CANDEN pins and the grants.
   always_comb begin
      en_next_s  = (state_next_s != ST_OFF);
      den_next_s = den_r;
      ack_next_s = {NREQ{1'b0}};
      // The path select only moves while the gate stays off across the edge.
      if ((state_r == ST_OFF) && (state_next_s == ST_OFF)) begin
         den_next_s = DYN_MODE;
      end else begin
         den_next_s = den_r;
      end
      if (state_next_s == ST_ON) begin
         ack_next_s = REQ;
      end else begin
         ack_next_s = {NREQ{1'b0}};
      end
   end

   // State, counter and output registers.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_r   <= ST_OFF;
         cnt_r     <= 8'd0;
         ack_r     <= {NREQ{1'b0}};
         sen_r     <= 1'b0;
         den_r     <= 1'b0;
         dynen_r   <= 1'b0;
         gate_on_r <= 1'b0;
      end else begin
         state_r   <= state_next_s;
         cnt_r     <= cnt_next_s;
         ack_r     <= ack_next_s;
         sen_r     <= en_next_s & ~den_next_s;
         den_r     <= den_next_s;
         dynen_r   <= en_next_s & den_next_s;
         gate_on_r <= en_next_s;
      end
   end

   assign ACK     = ack_r;
   assign SEN     = sen_r;
   assign DEN     = den_r;
   assign DYNEN   = dynen_r;
   assign GATE_ON = gate_on_r;
   assign STATE   = state_r;

`ifdef CANDEN_CTRL_STATS_EN
   logic [15:0] wake_count_r;
   logic [15:0] on_cycles_r;

   // Saturating statistics counters; a clear wins over an increment.
   always_ff @(posedge CLK) begin
      if (RST || CLR_STATS) begin
         wake_count_r <= 16'd0;
         on_cycles_r  <= 16'd0;
      end else begin
         if ((state_r == ST_OFF) && (state_next_s != ST_OFF) &&
             (wake_count_r != 16'hFFFF)) begin
            wake_count_r <= wake_count_r + 16'd1;
         end else begin
            wake_count_r <= wake_count_r;
         end
         if (gate_on_r && (on_cycles_r != 16'hFFFF)) begin
            on_cycles_r <= on_cycles_r + 16'd1;
         end else begin
            on_cycles_r <= on_cycles_r;
         end
      end
   end

   assign WAKE_COUNT = wake_count_r;
   assign ON_CYCLES  = on_cycles_r;
`endif

endmodule

// File: tb/tb_canden_ctrl.sv
// -----------------------------------------------------------------------------
// tb_canden_ctrl
// Directed steps followed by randomized traffic for canden_ctrl, checked
// against a timestamp-based behavioural model. A second instance with zero
// wake/idle times covers the single-cycle FORCE_ON pulse.
// -----------------------------------------------------------------------------
module tb_canden_ctrl;

   localparam int N = 4;
   localparam int W = 2;
   localparam int I = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [N-1:0]  req = 4'd0;
   logic          force_on = 1'b0;
   logic          dyn_mode = 1'b0;
   logic [N-1:0]  ack;
   logic          sen, den, dynen, gate_on;
   logic [1:0]    state;

   logic [N-1:0]  req0 = 4'd0;
   logic          force0 = 1'b0;
   logic [N-1:0]  ack0;
   logic          sen0, den0, dynen0, gate_on0;
   logic [1:0]    state0;

`ifdef CANDEN_CTRL_STATS_EN
   logic          clr_stats = 1'b0;
   logic [15:0]   wake_count, on_cycles;
   logic [15:0]   wake_count0, on_cycles0;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   canden_ctrl #(.NREQ(N), .WAKE_CYCLES(W), .IDLE_CYCLES(I)) dut (
      .CLK(clk), .RST(rst), .REQ(req), .FORCE_ON(force_on), .DYN_MODE(dyn_mode),
`ifdef CANDEN_CTRL_STATS_EN
      .CLR_STATS(clr_stats), .WAKE_COUNT(wake_count), .ON_CYCLES(on_cycles),
`endif
      .ACK(ack), .SEN(sen), .DEN(den), .DYNEN(dynen), .GATE_ON(gate_on), .STATE(state)
   );

   canden_ctrl #(.NREQ(N), .WAKE_CYCLES(0), .IDLE_CYCLES(0)) dut0 (
      .CLK(clk), .RST(rst), .REQ(req0), .FORCE_ON(force0), .DYN_MODE(1'b0),
`ifdef CANDEN_CTRL_STATS_EN
      .CLR_STATS(1'b0), .WAKE_COUNT(wake_count0), .ON_CYCLES(on_cycles0),
`endif
      .ACK(ack0), .SEN(sen0), .DEN(den0), .DYNEN(dynen0), .GATE_ON(gate_on0), .STATE(state0)
   );

   // ---------------- behavioural model (timestamps, not states) -------------
   int       k = 0;          // edge number
   bit       m_gate = 1'b0;  // gate enabled
   bit       m_ready = 1'b0; // settle time elapsed
   bit       m_idle = 1'b0;  // counting an idle gap
   bit       m_den = 1'b0;
   int       m_t_on = 0;
   int       m_t_idle = 0;
   logic [N-1:0] m_ack = 4'd0;
   int       m_wake_cnt = 0;
   int       m_on_cyc = 0;

   task automatic model_edge();
      bit any_v;
      bit was_gate;
      k++;
      if (rst) begin
         m_gate = 1'b0; m_ready = 1'b0; m_idle = 1'b0; m_den = 1'b0;
         m_ack = 4'd0; m_wake_cnt = 0; m_on_cyc = 0;
         return;
      end
      any_v    = (req != 4'd0) || force_on;
      was_gate = m_gate;
      if (!m_gate) begin
         if (any_v) begin
            m_gate = 1'b1; m_t_on = k; m_ready = (W == 0); m_idle = 1'b0;
         end
      end else if (!m_ready) begin
         if (k == m_t_on + W) m_ready = 1'b1;
      end else if (!m_idle) begin
         if (!any_v) begin
            if (I == 0) m_gate = 1'b0;
            else begin m_idle = 1'b1; m_t_idle = k; end
         end
      end else begin
         if (any_v) m_idle = 1'b0;
         else if (k == m_t_idle + I) m_gate = 1'b0;
      end
      if (!m_gate) begin m_ready = 1'b0; m_idle = 1'b0; end
      if (!was_gate && !m_gate) m_den = dyn_mode;
      m_ack = (m_gate && m_ready && !m_idle) ? req : 4'd0;
      if (!was_gate && m_gate && m_wake_cnt < 65535) m_wake_cnt++;
      if (was_gate && m_on_cyc < 65535) m_on_cyc++;
`ifdef CANDEN_CTRL_STATS_EN
      if (clr_stats) begin m_wake_cnt = 0; m_on_cyc = 0; end
`endif
   endtask

   function automatic logic [1:0] m_state();
      if (!m_gate)      return 2'd0;
      else if (!m_ready) return 2'd1;
      else if (m_idle)  return 2'd3;
      else              return 2'd2;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic check_model();
      check("state",   32'(state),   32'(m_state()));
      check("ack",     32'(ack),     32'(m_ack));
      check("sen",     32'(sen),     32'(m_gate & ~m_den));
      check("den",     32'(den),     32'(m_den));
      check("dynen",   32'(dynen),   32'(m_gate & m_den));
      check("gate_on", 32'(gate_on), 32'(m_gate));
`ifdef CANDEN_CTRL_STATS_EN
      check("wake_count", 32'(wake_count), 32'(m_wake_cnt));
      check("on_cycles",  32'(on_cycles),  32'(m_on_cyc));
`endif
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      check_model();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      bit busy;
      int wc_before;
      busy = 1'b0;

      // Reset
      repeat (3) tick();
      check("rst_state0", 32'(state0), 32'd0);
      check("rst_ack", 32'(ack), 32'd0);
      rst = 1'b0;
      tick();

      // Wake latency, static mode
      req = 4'b0001;
      tick();
      check("wake_sen", 32'(sen), 32'd1);
      check("wake_state", 32'(state), 32'd1);
      tick();
      check("wake_ack_early", 32'(ack), 32'd0);
      tick();
      check("on_ack", 32'(ack), 32'd1);
      check("on_state", 32'(state), 32'd2);
      check("on_dynen", 32'(dynen), 32'd0);
      check("on_den", 32'(den), 32'd0);

      // Idle timeout
      req = 4'd0;
      tick();
      check("hold_ack", 32'(ack), 32'd0);
      check("hold_state", 32'(state), 32'd3);
      for (int i = 0; i < 7; i++) begin
         tick();
         check("hold_sen", 32'(sen), 32'd1);
      end
      tick();
      check("off_sen", 32'(sen), 32'd0);
      check("off_state", 32'(state), 32'd0);

      // Re-request from HOLD with cnt=3
      req = 4'b0001;
      repeat (3) tick();
      check("on2_state", 32'(state), 32'd2);
      req = 4'd0;
      tick();
      repeat (5) tick();
      check("hold3_state", 32'(state), 32'd3);
      wc_before = m_wake_cnt;
      req = 4'b0100;
      tick();
      check("rehold_state", 32'(state), 32'd2);
      check("rehold_ack", 32'(ack), 32'b0100);
`ifdef CANDEN_CTRL_STATS_EN
      check("rehold_wake_count", 32'(wake_count), 32'(wc_before));
`endif

      // DYN_MODE change while on is deferred until the gate is off
      dyn_mode = 1'b1;
      tick();
      check("dyn_on_den", 32'(den), 32'd0);
      req = 4'd0;
      repeat (9) tick();
      check("dyn_off_state", 32'(state), 32'd0);
      check("dyn_off_den", 32'(den), 32'd0);
      tick();
      check("dyn_load_den", 32'(den), 32'd1);
      // DYN_MODE flipping on the OFF->WAKE edge is not captured
      req = 4'b0001;
      dyn_mode = 1'b0;
      tick();
      check("dyn_wake_dynen", 32'(dynen), 32'd1);
      check("dyn_wake_sen", 32'(sen), 32'd0);
      check("dyn_wake_den", 32'(den), 32'd1);

      // Zero wake/idle instance: one-cycle FORCE_ON pulse
      force0 = 1'b1;
      tick();
      check("z_gate_on", 32'(gate_on0), 32'd1);
      check("z_state", 32'(state0), 32'd2);
      check("z_ack", 32'(ack0), 32'd0);
      check("z_sen", 32'(sen0), 32'd1);
      force0 = 1'b0;
      tick();
      check("z_gate_off", 32'(gate_on0), 32'd0);
      check("z_state_off", 32'(state0), 32'd0);
      tick();
      check("z_gate_stay_off", 32'(gate_on0), 32'd0);

      // Reset during WAKE, then full restart
      req = 4'd0;
      repeat (12) tick();
      check("pre_rst_state", 32'(state), 32'd0);
      req = 4'hF;
      tick();
      check("rw_state", 32'(state), 32'd1);
      rst = 1'b1;
      tick();
      check("rw_state_rst", 32'(state), 32'd0);
      check("rw_sen", 32'(sen), 32'd0);
      check("rw_dynen", 32'(dynen), 32'd0);
      check("rw_den", 32'(den), 32'd0);
      check("rw_ack", 32'(ack), 32'd0);
      rst = 1'b0;
      tick();
      check("rs_state1", 32'(state), 32'd1);
      tick();
      check("rs_state2", 32'(state), 32'd1);
      check("rs_ack2", 32'(ack), 32'd0);
      tick();
      check("rs_state3", 32'(state), 32'd2);
      check("rs_ack3", 32'(ack), 32'hF);

      // Randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 15) == 0) busy = ~busy;
         if (busy) req = 4'($urandom);
         else if ($urandom_range(0, 31) == 0) req = 4'($urandom);
         else req = 4'd0;
         force_on = busy && ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 7) == 0) dyn_mode = ~dyn_mode;
         rst = ($urandom_range(0, 299) == 0);
`ifdef CANDEN_CTRL_STATS_EN
         clr_stats = ($urandom_range(0, 63) == 0);
`endif
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
